fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 33 +++
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/fetch_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared widths, FSM encodings and types for the instruction fetch unit.
// ADDR_SIZE / INSTR_SIZE mirror the project-wide def_params definitions;
// the guards let a real def_params header take precedence when present.
`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 31
`endif
`ifndef FETCH_IDLE
`define FETCH_IDLE 2'd0
`endif
`ifndef FETCH_REQ
`define FETCH_REQ 2'd1
`endif
`ifndef FETCH_DROP
`define FETCH_DROP 2'd2
`endif

package fetch_unit_pkg;
  localparam int ADDR_W  = `ADDR_SIZE + 1;
  localparam int INSTR_W = `INSTR_SIZE + 1;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  // IDLE: no read; REQ: read at fetch_pc; DROP: finishing an abandoned read
  typedef enum logic [1:0] {
    ST_IDLE = `FETCH_IDLE,
    ST_REQ  = `FETCH_REQ,
    ST_DROP = `FETCH_DROP
  } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue: DEPTH entries of {pc, instr}, synchronous flush.
// Head outputs show the oldest entry; when empty they hold the last head
// that was presented so the consumer never sees stale slot contents.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  addr_t                     push_pc,
  input  instr_t                    push_data,
  output logic [$clog2(DEPTH):0]    count,
  output addr_t                     head_pc,
  output instr_t                    head_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  addr_t              mem_pc   [DEPTH];
  instr_t             mem_data [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  addr_t              last_pc;
  instr_t             last_data;
  logic               pop_ok;
  logic               push_ok;
  logic               not_empty;

  assign not_empty = (count != '0);
  assign pop_ok    = pop && not_empty;
  assign push_ok   = push && ((count != CNT_W'(DEPTH)) || pop_ok);

  // Pointer, count and storage update; flush wins over push and pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_data[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem_pc[wr_ptr]   <= push_pc;
        mem_data[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Remember the most recently presented head for the empty case
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_pc   <= '0;
      last_data <= '0;
    end else if (not_empty) begin
      last_pc   <= mem_pc[rd_ptr];
      last_data <= mem_data[rd_ptr];
    end
  end

  assign head_pc   = not_empty ? mem_pc[rd_ptr]   : last_pc;
  assign head_data = not_empty ? mem_data[rd_ptr] : last_data;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential fetch into a small queue with redirect.
// Handshakes: a memory read completes at a rising edge where
// imem_rd_enable=1 and imem_rd_ready=1 (address held stable until then);
// the consumer pops at a rising edge where instr_valid=1 and instr_accept=1.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter addr_t       RESET_PC = '0,
  parameter int unsigned PC_STEP  = 4,
  parameter int          DEPTH    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         redirect_valid,
  input  addr_t        redirect_pc,
  output addr_t        imem_rd_addr,
  output logic         imem_rd_enable,
  input  instr_t       imem_rd_data,
  input  logic         imem_rd_ready,
  output logic         instr_valid,
  output instr_t       instr_data,
  output addr_t        instr_pc,
  input  logic         instr_accept,
  output fetch_state_e fsm_state
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e     state;
  addr_t            fetch_pc;
  addr_t            next_pc;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             full_after;

  assign next_pc     = fetch_pc + ADDR_W'(PC_STEP);
  assign instr_valid = (count != '0);
  // Redirect overrides both the same-edge pop and the push
  assign pop         = instr_accept && instr_valid && !redirect_valid;
  assign push        = (state == ST_REQ) && imem_rd_ready && !redirect_valid;
  assign full_after  = push && !pop && (count == CNT_W'(DEPTH - 1));
  assign fsm_state   = state;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_pc   (fetch_pc),
    .push_data (imem_rd_data),
    .count     (count),
    .head_pc   (instr_pc),
    .head_data (instr_data)
  );

  // Fetch FSM with registered memory-request outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      fetch_pc       <= RESET_PC;
      imem_rd_enable <= 1'b0;
      imem_rd_addr   <= RESET_PC;
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirect_valid) begin
            fetch_pc       <= redirect_pc;
            imem_rd_addr   <= redirect_pc;
            imem_rd_enable <= 1'b1;
            state          <= ST_REQ;
          end else if (count < CNT_W'(DEPTH)) begin
            imem_rd_addr   <= fetch_pc;
            imem_rd_enable <= 1'b1;
            state          <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            if (imem_rd_ready) begin
              // Data of this edge is discarded; start at the new target
              imem_rd_addr <= redirect_pc;
            end else begin
              // Read still in flight: keep its address until it completes
              state <= ST_DROP;
            end
          end else if (imem_rd_ready) begin
            fetch_pc     <= next_pc;
            imem_rd_addr <= next_pc;
            if (full_after) begin
              imem_rd_enable <= 1'b0;
              state          <= ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_pc;
          end
          if (imem_rd_ready) begin
            imem_rd_addr <= redirect_valid ? redirect_pc : fetch_pc;
            state        <= ST_REQ;
          end
        end
        default: begin
          state          <= ST_IDLE;
          imem_rd_enable <= 1'b0;
        end
      endcase
    end
  end
endmodule
